// File: rtl/multi_4bit_core_if.sv
// Operand/result bus for the 4x4 array multiplier.
// The master side supplies operands; the slave side returns the registered result.
interface multi_4bit_core_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       cin;
  logic       in_valid;
  logic [7:0] C;
  logic       out_valid;

  modport master (
    output A,
    output B,
    output cin,
    output in_valid,
    input  C,
    input  out_valid
  );

  modport slave (
    input  A,
    input  B,
    input  cin,
    input  in_valid,
    output C,
    output out_valid
  );
endinterface

// File: rtl/multi_4bit_core.sv
// Unsigned 4x4 array multiplier with carry-in: C = A*B + cin.
// AND-gate partial products are reduced by three ripple adder rows; the
// carry-in enters the bit-0 position of the first row. One register stage.
module multi_4bit_core (
  input  logic                  clk,
  input  logic                  reset,
  multi_4bit_core_if.slave      bus
);

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Full-adder carry bit.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // One ripple adder row built from full adders, 8 bits wide.
  function automatic logic [7:0] ripple_add(input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic       ci);
    logic [7:0] s;
    logic       c;
    s = 8'h00;
    c = ci;
    for (int k = 0; k < 8; k++) begin
      s[k] = fa_sum(x[k], y[k], c);
      c    = fa_carry(x[k], y[k], c);
    end
    return s;
  endfunction

  logic [3:0] pp_s [4];
  logic [7:0] row1_s;
  logic [7:0] row2_s;
  logic [7:0] row3_s;

  // Partial products: pp[i][j] = A[j] & B[i].
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp_s[i][j] = bus.A[j] & bus.B[i];
      end
    end
  end

  // Three adder rows fold the four shifted partial-product rows; the
  // first row takes cin as its bit-0 carry so the sum never needs a fifth row.
  always_comb begin
    row1_s = ripple_add({4'h0, pp_s[0]}, {3'b000, pp_s[1], 1'b0}, bus.cin);
    row2_s = ripple_add(row1_s, {2'b00, pp_s[2], 2'b00}, 1'b0);
    row3_s = ripple_add(row2_s, {1'b0, pp_s[3], 3'b000}, 1'b0);
  end

  // Result register: capture on valid input, hold C otherwise; reset clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.C         <= 8'h00;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.C         <= row3_s;
      bus.out_valid <= 1'b1;
    end else begin
      bus.C         <= bus.C;
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_4bit_core.sv
// Scoreboard bench for multi_4bit_core: the driver pushes one expected
// (out_valid, C) pair per clock edge, the monitor pops and compares.
module tb_multi_4bit_core;

  logic clk;
  logic reset;

  multi_4bit_core_if bus ();

  multi_4bit_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [7:0] c;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  logic [7:0] held_c;   // reference model of the value C keeps when idle

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one edge with given inputs; expectation from plain arithmetic.
  task automatic cycle(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic ci, input string tag);
    exp_t e;
    int   p;
    reset        = r;
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.cin      = ci;
    p = int'(a) * int'(b) + int'(ci);
    if (r) begin
      held_c = 8'h00;
      e.v = 1'b0;
    end else if (v) begin
      held_c = p[7:0];
      e.v = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.c   = held_c;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: after each edge compare the DUT against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.out_valid !== e.v) begin
        n_bad++;
        $display("FAIL %s out_valid: got %b expected %b", e.tag, bus.out_valid, e.v);
      end
      n_cmp++;
      if (bus.C !== e.c) begin
        n_bad++;
        $display("FAIL %s C: got %02h expected %02h", e.tag, bus.C, e.c);
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    held_c = 8'h00;

    // Reset held for two edges with live operands.
    cycle(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, "reset0");
    cycle(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, "reset1");
    cycle(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, "first_e1");

    // Exhaustive sweep, cin=0.
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        cycle(1'b0, 1'b1, 4'(a), 4'(b), 1'b0, "sweep");
      end
    end

    // Carry-in boundaries.
    cycle(1'b0, 1'b1, 4'h0, 4'h0, 1'b1, "cin_zero");
    cycle(1'b0, 1'b1, 4'hF, 4'hF, 1'b1, "cin_max");
    cycle(1'b0, 1'b1, 4'h7, 4'h9, 1'b1, "cin_7x9");
    cycle(1'b0, 1'b1, 4'h0, 4'hB, 1'b1, "cin_a0");
    cycle(1'b0, 1'b1, 4'hD, 4'h0, 1'b0, "b0");

    // Hold: idle cycles with changing operands leave C alone.
    cycle(1'b0, 1'b1, 4'h6, 4'h7, 1'b0, "hold_load");
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)),
            1'($urandom_range(1)), "hold");
    end

    // Reset in the middle of a back-to-back stream.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 4'(k + 3), 4'(k + 9), 1'b0, "stream_pre");
    end
    cycle(1'b1, 1'b1, 4'hC, 4'hA, 1'b1, "stream_reset");
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 4'(k + 12), 4'(k + 5), 1'(k), "stream_post");
    end

    // Randomized traffic with occasional idle and reset cycles.
    for (int k = 0; k < 200; k++) begin
      cycle(($urandom_range(19) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
            4'($urandom_range(15)), 4'($urandom_range(15)),
            1'($urandom_range(1)), "random");
    end

    // Drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #3;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
